fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 27 ++
 rtl/fwd_hazard_unit_if.sv | 33 +++
 rtl/fwd_prio_sel.sv | 42 ++++
 rtl/fwd_hazard_unit.sv | 74 +++++++
 tb/tb_fwd_hazard_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_hazard_unit_pkg : bypass select encodings and stage entries   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package fwd_hazard_unit_pkg;

    // Widest register address any pipeline stage entry can carry.
    localparam int AW_MAX = 16;

    // Bypass select encoding: 0 = register file, k = stage k (1 = EX).
    localparam int BP_SEL_RF = 0;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              load;
        logic [AW_MAX-1:0] dest;
    } stg_entry_t;

    // r0 is hardwired, so a write to it never forwards.
    function automatic logic entry_match(input stg_entry_t e, input logic [AW_MAX-1:0] addr);
        return e.valid && e.wen && (e.dest == addr) && (addr != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_hazard_unit_if : decode-side hazard/bypass bus                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fwd_hazard_unit_if #(
    parameter int NSRC = 2,
    parameter int NSTG = 3,
    parameter int AW   = 5,
    parameter int SW   = $clog2(NSTG + 1)
);
    logic                 in_valid;
    logic [AW-1:0]        in_dest;
    logic                 in_wen;
    logic                 in_load;
    logic [NSRC*AW-1:0]   src_addr;
    logic                 stall_ext;
    logic                 flush;
    logic [NSRC*SW-1:0]   bp_sel;
    logic                 ld_stall;
    logic [15:0]          stall_cnt;

    modport master (
        output in_valid, in_dest, in_wen, in_load, src_addr, stall_ext, flush,
        input  bp_sel, ld_stall, stall_cnt
    );

    modport slave (
        input  in_valid, in_dest, in_wen, in_load, src_addr, stall_ext, flush,
        output bp_sel, ld_stall, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fwd_prio_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_prio_sel : youngest-match bypass select for one source port   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fwd_prio_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NSTG = 3,
    parameter int AW   = 5,
    parameter int SW   = $clog2(NSTG + 1)
) (
    input  stg_entry_t [NSTG:1] ents,
    input  logic [AW-1:0]       src,
    output logic [SW-1:0]       sel,
    output logic                ld_hit
);

    logic [AW_MAX-1:0] w_src;
    logic [NSTG:1]     w_unused_load;

    assign w_src = AW_MAX'(src);

    // Scan oldest to youngest so the lowest matching stage is the last write.
    always_comb begin
        sel = SW'(BP_SEL_RF);
        for (int k = NSTG; k >= 1; k--) begin
            if (entry_match(ents[k], w_src)) begin
                sel = SW'(k);
            end
        end
        ld_hit = entry_match(ents[1], w_src) && ents[1].load;
    end

    always_comb begin
        for (int k = 1; k <= NSTG; k++) begin
            w_unused_load[k] = ents[k].load;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_hazard_unit : operand bypass selection and load-use interlock |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int NSTG = 3,
    parameter int AW   = 5,
    parameter int SW   = $clog2(NSTG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);

    stg_entry_t [NSTG:1]  r_stg;
    logic [15:0]          r_stall_cnt;
    stg_entry_t           w_dec;
    logic [NSRC*SW-1:0]   w_bp_sel;
    logic [NSRC-1:0]      w_ld_hit;
    logic                 w_ld_stall;

    generate
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            fwd_prio_sel #(
                .NSTG (NSTG),
                .AW   (AW),
                .SW   (SW)
            ) u_sel (
                .ents   (r_stg),
                .src    (bus.src_addr[s*AW +: AW]),
                .sel    (w_bp_sel[s*SW +: SW]),
                .ld_hit (w_ld_hit[s])
            );
        end
    endgenerate

    assign w_ld_stall = bus.in_valid && (|w_ld_hit);

    // A stalled or flushed decode instruction becomes a bubble in stage 1.
    always_comb begin
        w_dec       = '0;
        w_dec.valid = bus.in_valid && !w_ld_stall && !bus.flush;
        w_dec.wen   = bus.in_wen;
        w_dec.load  = bus.in_load;
        w_dec.dest  = AW_MAX'(bus.in_dest);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg       <= '0;
            r_stall_cnt <= 16'd0;
        end else if (!bus.stall_ext) begin
            for (int k = NSTG; k >= 2; k--) begin
                r_stg[k] <= r_stg[k-1];
            end
            r_stg[1] <= w_dec;
            if (w_ld_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end else if (bus.flush) begin
            r_stg[1].valid <= 1'b0;
        end
    end

    assign bus.bp_sel    = w_bp_sel;
    assign bus.ld_stall  = w_ld_stall;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fwd_hazard_unit : scoreboard bench for two parameterisations   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NSRC(2), .NSTG(3), .AW(5)) bus_a ();
    fwd_hazard_unit_if #(.NSRC(3), .NSTG(4), .AW(5)) bus_b ();

    fwd_hazard_unit #(.NSRC(2), .NSTG(3), .AW(5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    fwd_hazard_unit #(.NSRC(3), .NSTG(4), .AW(5)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    string       q_tag[$];
    bit          q_dut[$];
    logic [31:0] q_bp[$];
    logic        q_ld[$];
    logic [15:0] q_cnt[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit use_b, input logic [31:0] bp,
                            input logic ld, input logic [15:0] cnt);
        q_tag.push_back(tag);
        q_dut.push_back(use_b);
        q_bp.push_back(bp);
        q_ld.push_back(ld);
        q_cnt.push_back(cnt);
    endtask

    task automatic pop_cmp();
        string       tag;
        bit          use_b;
        logic [31:0] bp;
        logic        ld;
        logic [15:0] cnt;
        if (q_tag.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        tag   = q_tag.pop_front();
        use_b = q_dut.pop_front();
        bp    = q_bp.pop_front();
        ld    = q_ld.pop_front();
        cnt   = q_cnt.pop_front();
        if (use_b) begin
            check_val({tag, ".bp_sel"},    32'(bus_b.bp_sel),    bp);
            check_val({tag, ".ld_stall"},  32'(bus_b.ld_stall),  32'(ld));
            check_val({tag, ".stall_cnt"}, 32'(bus_b.stall_cnt), 32'(cnt));
        end else begin
            check_val({tag, ".bp_sel"},    32'(bus_a.bp_sel),    bp);
            check_val({tag, ".ld_stall"},  32'(bus_a.ld_stall),  32'(ld));
            check_val({tag, ".stall_cnt"}, 32'(bus_a.stall_cnt), 32'(cnt));
        end
    endtask

    task automatic drv_a(input logic v, input logic w, input logic l, input logic [4:0] d,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic st, input logic fl);
        bus_a.in_valid  = v;
        bus_a.in_wen    = w;
        bus_a.in_load   = l;
        bus_a.in_dest   = d;
        bus_a.src_addr  = {s1, s0};
        bus_a.stall_ext = st;
        bus_a.flush     = fl;
    endtask

    task automatic drv_b(input logic v, input logic w, input logic [4:0] d,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
        bus_b.in_valid  = v;
        bus_b.in_wen    = w;
        bus_b.in_load   = 1'b0;
        bus_b.in_dest   = d;
        bus_b.src_addr  = {s2, s1, s0};
        bus_b.stall_ext = 1'b0;
        bus_b.flush     = 1'b0;
    endtask

    // One decode cycle on the NSRC=2/NSTG=3 unit: drive, then check outputs before the edge.
    task automatic cyc_a(input string tag, input logic v, input logic w, input logic l,
                         input logic [4:0] d, input logic [4:0] s0, input logic [4:0] s1,
                         input logic st, input logic fl,
                         input logic [31:0] bp, input logic ld, input logic [15:0] cnt);
        @(negedge clk);
        drv_a(v, w, l, d, s0, s1, st, fl);
        push_exp(tag, 1'b0, bp, ld, cnt);
        #1;
        pop_cmp();
    endtask

    task automatic cyc_b(input string tag, input logic v, input logic w, input logic [4:0] d,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] bp);
        @(negedge clk);
        drv_b(v, w, d, s0, s1, s2);
        push_exp(tag, 1'b1, bp, 1'b0, 16'd0);
        #1;
        pop_cmp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drv_a(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0);
        drv_b(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5);
        #2;
        push_exp("rst_a", 1'b0, 32'd0, 1'b0, 16'd0);
        push_exp("rst_b", 1'b1, 32'd0, 1'b0, 16'd0);
        pop_cmp();
        pop_cmp();
        drv_a(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        drv_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv_a(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7, 1'b0, 1'b0);
        #1;
        push_exp("rst_release", 1'b0, 32'd0, 1'b0, 16'd0);
        pop_cmp();

        // ALU write to r5 walks EX -> MEM -> WB -> retired.
        cyc_a("r5_issue", 1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd0);
        cyc_a("r5_s1",    0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 32'd1, 0, 16'd0);
        cyc_a("r5_s2",    0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 32'd2, 0, 16'd0);
        cyc_a("r5_s3",    0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 32'd3, 0, 16'd0);
        cyc_a("r5_gone",  0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 32'd0, 0, 16'd0);

        // Load-use on src1: one stall, bubble in stage 1, then forward from stage 2.
        cyc_a("ld7_issue", 1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 32'd0,  0, 16'd0);
        cyc_a("ld7_use",   1, 1, 0, 5'd9, 5'd9, 5'd7, 0, 0, 32'd4,  1, 16'd0);
        cyc_a("ld7_fwd",   1, 1, 0, 5'd9, 5'd9, 5'd7, 0, 0, 32'd8,  0, 16'd1);
        cyc_a("ld7_after", 0, 0, 0, 5'd0, 5'd9, 5'd7, 0, 0, 32'd13, 0, 16'd1);

        // r3 in stages 1 and 3: youngest wins; r0 never forwards.
        cyc_a("r3_a",     1, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd1);
        cyc_a("r5_mid",   1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd1);
        cyc_a("r3_b",     1, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd1);
        cyc_a("r3_young", 1, 1, 0, 5'd0, 5'd3, 5'd5, 0, 0, 32'd9, 0, 16'd1);
        cyc_a("r0_never", 0, 0, 0, 5'd0, 5'd0, 5'd3, 0, 0, 32'd8, 0, 16'd1);

        // External freeze with a pending load-use, then flush of stage 1 only.
        cyc_a("r12_issue", 1, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd1);
        cyc_a("ld7b_issue", 1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'd1);
        for (int i = 0; i < 4; i++) begin
            cyc_a($sformatf("frz%0d", i), 1, 0, 0, 5'd0, 5'd12, 5'd7, 1, 0, 32'd6, 1, 16'd1);
        end
        cyc_a("frz_flush",  1, 0, 0, 5'd0, 5'd12, 5'd7, 1, 1, 32'd6, 1, 16'd1);
        cyc_a("post_flush", 1, 0, 0, 5'd0, 5'd12, 5'd7, 0, 0, 32'd2, 0, 16'd1);

        // Preload the counter just below saturation.
        force dut_a.r_stall_cnt = 16'hFFFE;
        release dut_a.r_stall_cnt;
        cyc_a("sat_ld",   1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'hFFFE);
        cyc_a("sat_use1", 1, 0, 0, 5'd0, 5'd0, 5'd7, 0, 0, 32'd4, 1, 16'hFFFE);
        cyc_a("sat_ld2",  1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'hFFFF);
        cyc_a("sat_use2", 1, 0, 0, 5'd0, 5'd0, 5'd7, 0, 0, 32'd4, 1, 16'hFFFF);
        cyc_a("sat_hold", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'hFFFF);

        // Asynchronous reset between edges in the middle of a load-use stall.
        cyc_a("rst_ld",  1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0, 32'd0, 0, 16'hFFFF);
        cyc_a("rst_use", 1, 0, 0, 5'd0, 5'd0, 5'd7, 0, 0, 32'd4, 1, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rst_async", 1'b0, 32'd0, 1'b0, 16'd0);
        pop_cmp();
        @(negedge clk);
        drv_a(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        push_exp("rst_async_rel", 1'b0, 32'd0, 1'b0, 16'd0);
        pop_cmp();

        // Same r5 walk on the NSRC=3 / NSTG=4 build, observed on src0 and src2.
        cyc_b("b_issue", 1, 1, 5'd5, 5'd0, 5'd0, 5'd0, 32'd0);
        cyc_b("b_s1",    0, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'd65);
        cyc_b("b_s2",    0, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'd130);
        cyc_b("b_s3",    0, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'd195);
        cyc_b("b_s4",    0, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'd260);
        cyc_b("b_gone",  0, 0, 5'd0, 5'd5, 5'd0, 5'd5, 32'd0);

        if (q_tag.size() != 0) begin
            check_val("scoreboard_leftover", 32'(q_tag.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
